// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, line/frame measurements and lock status from active-low VGA syncs.
// Build option: define VGA_INPUT_SYNC_EN to add a two-flop synchronizer on the sync inputs.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 29,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk_25,
    input  logic       reset_n,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos,
    output logic       active,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       err
);

    typedef enum logic [1:0] {UNLOCKED, ALIGN, TRAINING, LOCKED} state_t;

    localparam logic [9:0] H_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_HI = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_HI = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0] SAT  = 10'h3FF;

    logic hs, vs, hs_q, vs_q;
    logic hs_fall, vs_fall;

`ifdef VGA_INPUT_SYNC_EN
    logic hs_m, vs_m;
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            hs_m <= 1'b1;
            vs_m <= 1'b1;
            hs   <= 1'b1;
            vs   <= 1'b1;
        end else begin
            hs_m <= h_sync_in;
            vs_m <= v_sync_in;
            hs   <= hs_m;
            vs   <= vs_m;
        end
    end
`else
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            hs <= h_sync_in;
            vs <= v_sync_in;
        end
    end
`endif

    // Previous-value flops reset high so leaving reset never looks like a falling edge
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            hs_q <= hs;
            vs_q <= vs;
        end
    end

    assign hs_fall = hs_q & ~hs;
    assign vs_fall = vs_q & ~vs;

    logic [9:0] h_inc, v_inc;
    assign h_inc = (h_pos == SAT) ? h_pos : h_pos + 10'd1;
    assign v_inc = (v_pos == SAT) ? v_pos : v_pos + 10'd1;

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_pos       <= '0;
            v_pos       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (hs_fall) begin
                h_pos    <= '0;
                line_len <= h_inc;
            end else begin
                h_pos <= h_inc;
            end
            if (vs_fall) begin
                v_pos       <= '0;
                frame_lines <= v_inc;
            end else if (hs_fall) begin
                v_pos <= v_inc;
            end
        end
    end

    state_t     state, state_n;
    logic [3:0] good_cnt, good_n;
    logic [9:0] ref_len, ref_len_n, ref_lines, ref_lines_n;
    logic       mismatch;

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= UNLOCKED;
            good_cnt  <= '0;
            ref_len   <= '0;
            ref_lines <= '0;
        end else begin
            state     <= state_n;
            good_cnt  <= good_n;
            ref_len   <= ref_len_n;
            ref_lines <= ref_lines_n;
        end
    end

    // Saturation is flagged on the cycle before h_pos reaches 1023 so err fires only once
    assign mismatch = (hs_fall && (h_inc != ref_len)) ||
                      (vs_fall && (v_inc != ref_lines)) ||
                      (!hs_fall && (h_pos == SAT - 10'd1));

    always_comb begin
        state_n     = state;
        good_n      = good_cnt;
        ref_len_n   = ref_len;
        ref_lines_n = ref_lines;
        err         = 1'b0;
        case (state)
            UNLOCKED: if (vs_fall) state_n = ALIGN;
            ALIGN: begin
                if (vs_fall && line_len != '0) begin
                    ref_lines_n = v_inc;
                    ref_len_n   = line_len;
                    good_n      = '0;
                    state_n     = TRAINING;
                end
            end
            TRAINING: begin
                if (mismatch) begin
                    err     = 1'b1;
                    state_n = UNLOCKED;
                end else if (vs_fall) begin
                    good_n = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == 4'(LOCK_FRAMES)) state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    err     = 1'b1;
                    state_n = UNLOCKED;
                end
            end
            default: state_n = UNLOCKED;
        endcase
    end

    assign locked = (state == LOCKED);
    assign active = locked && (h_pos >= H_LO) && (h_pos < H_HI) &&
                    (v_pos >= V_LO) && (v_pos < V_HI);

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. Samples incoming active-low h_sync/v_sync and recovers pixel position (h_pos/v_pos) and an active-video flag. Measures line length and lines per frame, and asserts locked once timing is stable. Sits at the input of capture and monitor logic in the clk_25 domain, and doubles as a bench checker for the generator.

Parameters:
H_SYNC, 96, hsync low width in clocks; start of the h window offset
H_BACK, 48, clocks from end of hsync to first active pixel
H_ACTIVE, 640, active pixels per line
V_SYNC, 2, vsync low width in lines
V_BACK, 29, lines from end of vsync to first active line
V_ACTIVE, 480, active lines per frame
LOCK_FRAMES, 2, consecutive matching frames needed to lock (1..15)

Ports:
clk_25  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
h_sync_in  input  1  horizontal sync, active low
v_sync_in  input  1  vertical sync, active low
h_pos  output  10  clocks since last hsync falling edge, saturates at 1023
v_pos  output  10  hsync falls since last vsync falling edge, saturates at 1023
active  output  1  pixel inside active window while locked
locked  output  1  timing stable
line_len  output  10  last measured line length in clocks
frame_lines  output  10  last measured lines per frame
err  output  1  one-cycle pulse on timing violation

Behaviour:
- Input stage: hs/vs are the sampled sync signals; hs_q/vs_q hold their previous values. hs_fall = hs_q & ~hs; vs_fall = vs_q & ~vs.
- Reset: hs_q/vs_q = 1 (no spurious edge). h_pos, v_pos, line_len, frame_lines = 0. active, locked, err = 0. State = UNLOCKED, good_cnt = 0, ref_len = 0, ref_lines = 0.
- h counter: on hs_fall, h_pos <= 0 and line_len <= h_pos+1, saturating at 1023. Otherwise h_pos increments, saturating at 1023.
- v counter: on vs_fall, v_pos <= 0 and frame_lines <= v_pos+1, saturating. Else on hs_fall, v_pos increments, saturating.
- Simultaneous vs_fall and hs_fall: v_pos <= 0 (vsync wins); h counter handled as a normal hs_fall.
- active (combinational from registers): locked & (H_SYNC+H_BACK <= h_pos < H_SYNC+H_BACK+H_ACTIVE) & (V_SYNC+V_BACK <= v_pos < V_SYNC+V_BACK+V_ACTIVE).
- Lock FSM:
  UNLOCKED: on vs_fall -> ALIGN.
  ALIGN: on vs_fall, ref_lines <= v_pos+1, ref_len <= line_len, good_cnt <= 0 -> TRAINING. If line_len==0, stay in ALIGN.
  TRAINING: on vs_fall with v_pos+1 == ref_lines, good_cnt++; when the incremented value equals LOCK_FRAMES -> LOCKED.
  LOCKED: locked=1.
- Mismatch (TRAINING or LOCKED only): any of the following sends the FSM to UNLOCKED, pulses err for exactly 1 cycle, and drops locked on the next cycle.
  hs_fall with h_pos+1 != ref_len.
  vs_fall with v_pos+1 != ref_lines.
  h_pos reaching 1023 (hsync loss). err fires once on the transition to saturation, not every cycle.
- If a line and a frame mismatch occur in the same cycle, a single err pulse is generated.
- Reset mid-operation: all state returns to reset values immediately; relock requires the full ALIGN/TRAINING sequence.

Optional Feature:
VGA_INPUT_SYNC_EN
- Defined: two-flop synchronizer on h_sync_in and v_sync_in, both flops reset to 1; hs/vs are the second flop. h_pos==0 appears after the 3rd rising edge following a sampled input fall.
- Undefined: inputs are registered once (input assumed synchronous to clk_25). h_pos==0 appears after the 2nd rising edge.
- All other behaviour is identical with or without the macro.

Test Plan:
- Nominal frame, defaults (800-clock line, hsync low 96, 525-line frame, vsync low 2 lines) -> line_len=800, frame_lines=525; locked rises 1 cycle after the 4th vs_fall; active high for h_pos 144..783 and v_pos 31..510 (640x480 active clocks per frame).
- Locked, then one line shortened to 799 -> err high exactly 1 cycle at that hs_fall; locked low next cycle; relock after 4 further vs_falls.
- Locked, then hsync held high -> h_pos sticks at 1023; single err pulse; locked=0, active=0.
- hsync and vsync fall on the same clock -> v_pos=0 and h_pos=0 on the same cycle; frame_lines captures the count; no err.
- reset_n pulsed low mid-frame while locked -> all outputs 0 immediately (asynchronous); no err during or after reset; lock again after 4 vs_falls.
- Compare builds with and without VGA_INPUT_SYNC_EN -> h_pos==0 latency is 3 vs 2 clocks after the hsync input fall; counts otherwise identical.
